// File: rtl/bcd_two_digit_counter_if.sv
// Count-tick, control and digit bundle for bcd_two_digit_counter.
// Defining BCD_SEVEN_SEG_EN adds the registered 7-segment outputs.
interface bcd_two_digit_counter_if;
  logic       tick;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tc;
`ifdef BCD_SEVEN_SEG_EN
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
`endif

  // Single-beat protocol: no valid/ready pair. A step is requested by a
  // rising edge of tick qualified by en; load is a one-cycle strobe sampled
  // on every clkin edge and wins over a step in the same cycle.
`ifdef BCD_SEVEN_SEG_EN
  modport master (output tick, en, up, load, load_tens, load_ones,
                  input tens, ones, tc, seg_tens, seg_ones);
  modport slave  (input tick, en, up, load, load_tens, load_ones,
                  output tens, ones, tc, seg_tens, seg_ones);
`else
  modport master (output tick, en, up, load, load_tens, load_ones,
                  input tens, ones, tc);
  modport slave  (input tick, en, up, load, load_tens, load_ones,
                  output tens, ones, tc);
`endif
endinterface

// File: rtl/bcd_two_digit_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of a tick level,
// with clamped parallel load and a one-cycle terminal-count pulse.
// Optional feature macro: BCD_SEVEN_SEG_EN (registered active-low segments).
module bcd_two_digit_counter #(
    parameter int LIMIT = 99
) (
    input logic clkin,
    input logic clr,
    bcd_two_digit_counter_if.slave bus
);

    localparam logic [3:0] LIM_T = 4'(LIMIT / 10);
    localparam logic [3:0] LIM_O = 4'(LIMIT % 10);

    logic       tick_d;
    logic       step;
    logic [3:0] tens_q, ones_q, tens_n, ones_n;
    logic       tc_q, tc_n;
    logic [3:0] lt_c, lo_c;
    logic       at_limit, at_zero;

    assign step     = bus.tick & ~tick_d & bus.en;
    assign at_limit = (tens_q == LIM_T) && (ones_q == LIM_O);
    assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign lt_c     = (bus.load_tens > 4'd9) ? 4'd9 : bus.load_tens;
    assign lo_c     = (bus.load_ones > 4'd9) ? 4'd9 : bus.load_ones;

    always_comb begin
        tens_n = tens_q;
        ones_n = ones_q;
        tc_n   = 1'b0;
        if (bus.load) begin
            // Digit-wise compare is equivalent to comparing 10*t+o values.
            if ((lt_c > LIM_T) || ((lt_c == LIM_T) && (lo_c > LIM_O))) begin
                tens_n = LIM_T;
                ones_n = LIM_O;
            end else begin
                tens_n = lt_c;
                ones_n = lo_c;
            end
        end else if (step) begin
            if (bus.up) begin
                if (at_limit) begin
                    tens_n = 4'd0;
                    ones_n = 4'd0;
                    tc_n   = 1'b1;
                end else if (ones_q == 4'd9) begin
                    ones_n = 4'd0;
                    tens_n = tens_q + 4'd1;
                end else begin
                    ones_n = ones_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    tens_n = LIM_T;
                    ones_n = LIM_O;
                    tc_n   = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_n = 4'd9;
                    tens_n = tens_q - 4'd1;
                end else begin
                    ones_n = ones_q - 4'd1;
                end
            end
        end
    end

    // tick_d follows tick even during clr so a tick held high across reset
    // release is not mistaken for a fresh edge.
    always_ff @(posedge clkin) begin
        tick_d <= bus.tick;
        if (clr) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            tc_q   <= 1'b0;
        end else begin
            tens_q <= tens_n;
            ones_q <= ones_n;
            tc_q   <= tc_n;
        end
    end

    assign bus.tens = tens_q;
    assign bus.ones = ones_q;
    assign bus.tc   = tc_q;

`ifdef BCD_SEVEN_SEG_EN
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [6:0] seg_tens_q, seg_ones_q;

    always_ff @(posedge clkin) begin
        if (clr) begin
            seg_tens_q <= 7'b1000000;
            seg_ones_q <= 7'b1000000;
        end else begin
            seg_tens_q <= seg_enc(tens_q);
            seg_ones_q <= seg_enc(ones_q);
        end
    end

    assign bus.seg_tens = seg_tens_q;
    assign bus.seg_ones = seg_ones_q;
`endif

endmodule

// File: tb/tb_bcd_two_digit_counter.sv
// Directed bench for bcd_two_digit_counter: one instance at LIMIT=99 and
// one at LIMIT=59 share the same stimulus; each test checks the relevant one.
module tb_bcd_two_digit_counter;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic tick = 1'b0;
  logic en = 1'b0;
  logic up = 1'b1;
  logic load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bcd_two_digit_counter_if bus99 ();
  bcd_two_digit_counter_if bus59 ();

  assign bus99.tick = tick;       assign bus59.tick = tick;
  assign bus99.en = en;           assign bus59.en = en;
  assign bus99.up = up;           assign bus59.up = up;
  assign bus99.load = load;       assign bus59.load = load;
  assign bus99.load_tens = load_tens; assign bus59.load_tens = load_tens;
  assign bus99.load_ones = load_ones; assign bus59.load_ones = load_ones;

  bcd_two_digit_counter #(.LIMIT(99)) dut99 (.clkin(clk), .clr(clr), .bus(bus99.slave));
  bcd_two_digit_counter #(.LIMIT(59)) dut59 (.clkin(clk), .clr(clr), .bus(bus59.slave));

  // Inputs change on the falling edge; outputs are observed on the falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b1; tick = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; tick = 1'b1;
    repeat (5) cycle();
    tests_run++;
    if ({bus99.tens, bus99.ones, bus99.tc} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset99 got %0d%0d tc=%0b want 00 tc=0", bus99.tens, bus99.ones, bus99.tc);
    end
    tests_run++;
    if ({bus59.tens, bus59.ones, bus59.tc} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset59 got %0d%0d tc=%0b want 00 tc=0", bus59.tens, bus59.ones, bus59.tc);
    end
`ifdef BCD_SEVEN_SEG_EN
    tests_run++;
    if (bus99.seg_tens !== 7'b1000000 || bus99.seg_ones !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_seg got %b/%b want 1000000/1000000", bus99.seg_tens, bus99.seg_ones);
    end
`endif
    en = 1'b1; up = 1'b1;
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      tests_run++;
      if ({bus99.tens, bus99.ones, bus99.tc} !== 9'd0) begin
        tests_failed++;
        $display("FAIL release_tick_high cyc %0d got %0d%0d tc=%0b want 00 tc=0", i, bus99.tens, bus99.ones, bus99.tc);
      end
    end
    tick = 1'b0;
    cycle();
  endtask

  task automatic test_count_up();
    int exp_v;
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      exp_v = i % 100;
      tick = 1'b1;
      cycle();
      tests_run++;
      if (bus99.tens !== 4'(exp_v / 10) || bus99.ones !== 4'(exp_v % 10) || bus99.tc !== (exp_v == 0)) begin
        tests_failed++;
        $display("FAIL count_up step %0d got %0d%0d tc=%0b want %0d tc=%0b", i, bus99.tens, bus99.ones, bus99.tc, exp_v, exp_v == 0);
      end
      tick = 1'b0;
      cycle();
      tests_run++;
      if (bus99.tc !== 1'b0 || bus99.tens !== 4'(exp_v / 10) || bus99.ones !== 4'(exp_v % 10)) begin
        tests_failed++;
        $display("FAIL count_up_hold step %0d got %0d%0d tc=%0b want %0d tc=0", i, bus99.tens, bus99.ones, bus99.tc, exp_v);
      end
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    up = 1'b0;
    tick = 1'b1; cycle();
    tests_run++;
    if (bus59.tens !== 4'd5 || bus59.ones !== 4'd9 || bus59.tc !== 1'b1) begin
      tests_failed++;
      $display("FAIL down_wrap got %0d%0d tc=%0b want 59 tc=1", bus59.tens, bus59.ones, bus59.tc);
    end
    tick = 1'b0; cycle();
    tests_run++;
    if (bus59.tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_wrap_tc_width got tc=%0b want 0", bus59.tc);
    end
    tick = 1'b1; cycle();
    tests_run++;
    if (bus59.tens !== 4'd5 || bus59.ones !== 4'd8 || bus59.tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_next got %0d%0d tc=%0b want 58 tc=0", bus59.tens, bus59.ones, bus59.tc);
    end
    tick = 1'b0; cycle();
    // Borrow across the tens digit on the LIMIT=99 instance: 99 -> 98 ... check 10 -> 09.
    load = 1'b1; load_tens = 4'd1; load_ones = 4'd0; cycle();
    load = 1'b0;
    tick = 1'b1; cycle();
    tests_run++;
    if (bus99.tens !== 4'd0 || bus99.ones !== 4'd9 || bus99.tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_borrow got %0d%0d tc=%0b want 09 tc=0", bus99.tens, bus99.ones, bus99.tc);
    end
    tick = 1'b0; cycle();
    up = 1'b1;
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; load_tens = 4'd7; load_ones = 4'd3; cycle();
    tests_run++;
    if (bus59.tens !== 4'd5 || bus59.ones !== 4'd9 || bus59.tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_clamp_limit got %0d%0d tc=%0b want 59 tc=0", bus59.tens, bus59.ones, bus59.tc);
    end
    tests_run++;
    if (bus99.tens !== 4'd7 || bus99.ones !== 4'd3) begin
      tests_failed++;
      $display("FAIL load_plain got %0d%0d want 73", bus99.tens, bus99.ones);
    end
    load_tens = 4'd2; load_ones = 4'd12; cycle();
    tests_run++;
    if (bus59.tens !== 4'd2 || bus59.ones !== 4'd9) begin
      tests_failed++;
      $display("FAIL load_digit_clamp got %0d%0d want 29", bus59.tens, bus59.ones);
    end
    load = 1'b0; cycle();
    // Load and a tick edge together: only the load takes effect.
    load = 1'b1; tick = 1'b1; load_tens = 4'd1; load_ones = 4'd5; cycle();
    load = 1'b0; cycle();
    tests_run++;
    if (bus59.tens !== 4'd1 || bus59.ones !== 4'd5 || bus59.tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_with_tick got %0d%0d tc=%0b want 15 tc=0", bus59.tens, bus59.ones, bus59.tc);
    end
    tick = 1'b0; cycle();
    // Load of the wrap value must not pulse tc.
    load = 1'b1; load_tens = 4'd0; load_ones = 4'd0; cycle();
    load = 1'b0;
    tests_run++;
    if (bus99.tc !== 1'b0 || bus99.tens !== 4'd0 || bus99.ones !== 4'd0) begin
      tests_failed++;
      $display("FAIL load_no_tc got %0d%0d tc=%0b want 00 tc=0", bus99.tens, bus99.ones, bus99.tc);
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; cycle();
      tick = 1'b0; cycle();
      tests_run++;
      if (bus99.tens !== 4'd0 || bus99.ones !== 4'd0) begin
        tests_failed++;
        $display("FAIL en_low edge %0d got %0d%0d want 00", i, bus99.tens, bus99.ones);
      end
    end
    tick = 1'b1; cycle();
    en = 1'b1; cycle(); cycle();
    tests_run++;
    if (bus99.tens !== 4'd0 || bus99.ones !== 4'd0) begin
      tests_failed++;
      $display("FAIL en_raise_tick_high got %0d%0d want 00", bus99.tens, bus99.ones);
    end
    tick = 1'b0; cycle();
    tick = 1'b1; cycle();
    tests_run++;
    if (bus99.tens !== 4'd0 || bus99.ones !== 4'd1) begin
      tests_failed++;
      $display("FAIL en_fresh_edge got %0d%0d want 01", bus99.tens, bus99.ones);
    end
    tick = 1'b0; cycle();
  endtask

  task automatic test_back_to_back();
    // From 01: down, up, up with one low cycle between edges.
    up = 1'b0; tick = 1'b1; cycle(); tick = 1'b0; cycle();
    tests_run++;
    if (bus99.tens !== 4'd0 || bus99.ones !== 4'd0 || bus99.tc !== 1'b0) begin
      tests_failed++;
      $display("FAIL dir_down got %0d%0d tc=%0b want 00 tc=0", bus99.tens, bus99.ones, bus99.tc);
    end
    up = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick = 1'b1; cycle(); tick = 1'b0; cycle();
      tests_run++;
      if (bus99.tens !== 4'd0 || bus99.ones !== 4'(i)) begin
        tests_failed++;
        $display("FAIL b2b_up %0d got %0d%0d want 0%0d", i, bus99.tens, bus99.ones, i);
      end
    end
    // Reset wins over a simultaneous load and step.
    load = 1'b1; load_tens = 4'd4; load_ones = 4'd4; tick = 1'b1; clr = 1'b1; cycle();
    clr = 1'b0; load = 1'b0; tick = 1'b0;
    tests_run++;
    if ({bus99.tens, bus99.ones, bus99.tc} !== 9'd0) begin
      tests_failed++;
      $display("FAIL clr_priority got %0d%0d tc=%0b want 00 tc=0", bus99.tens, bus99.ones, bus99.tc);
    end
    cycle();
  endtask

`ifdef BCD_SEVEN_SEG_EN
  task automatic test_seven_seg();
    do_reset();
    cycle();
    load = 1'b1; load_tens = 4'd0; load_ones = 4'd7; cycle();
    load = 1'b0;
    tests_run++;
    if (bus99.ones !== 4'd7 || bus99.seg_ones !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL seg_lag got ones=%0d seg=%b want 7 / 1000000", bus99.ones, bus99.seg_ones);
    end
    cycle();
    tests_run++;
    if (bus99.seg_ones !== 7'b1111000 || bus99.seg_tens !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL seg_07 got %b/%b want 1000000/1111000", bus99.seg_tens, bus99.seg_ones);
    end
  endtask
`endif

  initial begin
    cycle();
    test_reset();
    test_count_up();
    test_down_wrap();
    test_load();
    test_enable();
    test_back_to_back();
`ifdef BCD_SEVEN_SEG_EN
    test_seven_seg();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
